// File: rtl/rob_commit_tracker.sv
// rtl/rob_commit_tracker.sv - in-order ROB tag tracker that retires completed tags oldest-first
// Tags enter a circular queue on alloc and retire up to MAX_NUM_OF_COMMITS per cycle once done.
module rob_commit_tracker #(
  parameter int ROB_SIZE           = 16,
  parameter int ROB_SIZE_WIDTH     = 4,
  parameter int MAX_NUM_OF_COMMITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_valid,
  input  logic [ROB_SIZE_WIDTH-1:0]     alloc_tag,
  input  logic                          cmpl_valid,
  input  logic [ROB_SIZE_WIDTH-1:0]     cmpl_tag,
  output logic [ROB_SIZE_WIDTH-1:0]     commited_tags [MAX_NUM_OF_COMMITS],
  output logic [MAX_NUM_OF_COMMITS-1:0] commited_tags_valid,
  output logic [ROB_SIZE_WIDTH:0]       inflight_count,
  output logic                          protocol_err
);
  localparam int PW = ROB_SIZE_WIDTH + 1;
  localparam int KW = $clog2(MAX_NUM_OF_COMMITS + 1);

  logic [ROB_SIZE_WIDTH-1:0]     queue [ROB_SIZE];
  logic [PW-1:0]                 head_ptr;
  logic [PW-1:0]                 tail_ptr;
  logic [ROB_SIZE-1:0]           inflight;
  logic [ROB_SIZE-1:0]           done;
  logic [ROB_SIZE-1:0]           inflight_nxt;
  logic [ROB_SIZE-1:0]           done_nxt;
  logic [KW-1:0]                 retire_cnt;
  logic [ROB_SIZE_WIDTH-1:0]     retire_tag [MAX_NUM_OF_COMMITS];
  logic [MAX_NUM_OF_COMMITS-1:0] retire_mask;
  logic                          blocked;
  logic                          full;
  logic                          alloc_retiring;
  logic                          alloc_ok;
  logic                          cmpl_ok;

  assign inflight_count = tail_ptr - head_ptr;
  assign full = (head_ptr[ROB_SIZE_WIDTH] != tail_ptr[ROB_SIZE_WIDTH]) &&
                (head_ptr[ROB_SIZE_WIDTH-1:0] == tail_ptr[ROB_SIZE_WIDTH-1:0]);

  // Retire the longest done prefix from head; the first not-done entry blocks the rest.
  always_comb begin
    retire_cnt     = '0;
    retire_mask    = '0;
    blocked        = 1'b0;
    alloc_retiring = 1'b0;
    for (int i = 0; i < MAX_NUM_OF_COMMITS; i++) begin
      retire_tag[i] = queue[head_ptr[ROB_SIZE_WIDTH-1:0] + ROB_SIZE_WIDTH'(i)];
      if (!blocked && (PW'(i) < inflight_count) && done[retire_tag[i]]) begin
        retire_mask[i] = 1'b1;
        retire_cnt     = KW'(i + 1);
        if (retire_tag[i] == alloc_tag) begin
          alloc_retiring = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  // A tag retiring this cycle may be handed out again in the same cycle.
  assign alloc_ok = alloc_valid && !full && (!inflight[alloc_tag] || alloc_retiring);
  assign cmpl_ok  = cmpl_valid && inflight[cmpl_tag] && !done[cmpl_tag];

  // Retire clears first so that a same-cycle re-allocation wins.
  always_comb begin
    inflight_nxt = inflight;
    done_nxt     = done;
    for (int i = 0; i < MAX_NUM_OF_COMMITS; i++) begin
      if (retire_mask[i]) begin
        inflight_nxt[retire_tag[i]] = 1'b0;
        done_nxt[retire_tag[i]]     = 1'b0;
      end
    end
    if (cmpl_ok) begin
      done_nxt[cmpl_tag] = 1'b1;
    end
    if (alloc_ok) begin
      inflight_nxt[alloc_tag] = 1'b1;
      done_nxt[alloc_tag]     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_ptr            <= '0;
      tail_ptr            <= '0;
      inflight            <= '0;
      done                <= '0;
      commited_tags_valid <= '0;
      protocol_err        <= 1'b0;
      for (int i = 0; i < MAX_NUM_OF_COMMITS; i++) begin
        commited_tags[i] <= '0;
      end
    end else begin
      head_ptr            <= head_ptr + PW'(retire_cnt);
      if (alloc_ok) begin
        tail_ptr <= tail_ptr + PW'(1);
      end
      inflight            <= inflight_nxt;
      done                <= done_nxt;
      commited_tags_valid <= retire_mask;
      protocol_err        <= (alloc_valid && !alloc_ok) || (cmpl_valid && !cmpl_ok);
      for (int i = 0; i < MAX_NUM_OF_COMMITS; i++) begin
        commited_tags[i] <= retire_mask[i] ? retire_tag[i] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && alloc_ok) begin
      queue[tail_ptr[ROB_SIZE_WIDTH-1:0]] <= alloc_tag;
    end
  end

endmodule

// File: tb/tb_rob_commit_tracker.sv
// tb/tb_rob_commit_tracker.sv - scoreboard bench for rob_commit_tracker
// A program-order queue model predicts each cycle's outputs; a negedge monitor compares them.
module tb_rob_commit_tracker;
  localparam int RS = 16;
  localparam int RW = 4;
  localparam int MC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          alloc_valid = 1'b0;
  logic [RW-1:0] alloc_tag = '0;
  logic          cmpl_valid = 1'b0;
  logic [RW-1:0] cmpl_tag = '0;
  logic [RW-1:0] commited_tags [MC];
  logic [MC-1:0] commited_tags_valid;
  logic [RW:0]   inflight_count;
  logic          protocol_err;

  rob_commit_tracker #(
    .ROB_SIZE(RS),
    .ROB_SIZE_WIDTH(RW),
    .MAX_NUM_OF_COMMITS(MC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .alloc_valid(alloc_valid),
    .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid),
    .cmpl_tag(cmpl_tag),
    .commited_tags(commited_tags),
    .commited_tags_valid(commited_tags_valid),
    .inflight_count(inflight_count),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   due;
    logic [MC-1:0]        vld;
    logic [MC-1:0][RW-1:0] tags;
    logic                 perr;
    int                   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   mq[$];
  bit   m_done [RS];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_q(input int t);
    foreach (mq[i]) if (mq[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick_free();
    int s = $urandom_range(0, RS - 1);
    for (int j = 0; j < RS; j++) if (!in_q((s + j) % RS)) return (s + j) % RS;
    return s;
  endfunction

  function automatic int pick_pending();
    int s;
    if (mq.size() == 0) return $urandom_range(0, RS - 1);
    s = $urandom_range(0, mq.size() - 1);
    for (int j = 0; j < mq.size(); j++) if (!m_done[mq[(s + j) % mq.size()]]) return mq[(s + j) % mq.size()];
    return $urandom_range(0, RS - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle, predict what the DUT shows after the coming edge, queue it.
  task automatic step(input bit av, input int at, input bit cv, input int ct, input bit rst);
    exp_t e;
    int   k;
    bit   a_ok, c_ok, in_ret;
    alloc_valid = av;
    alloc_tag   = RW'(at);
    cmpl_valid  = cv;
    cmpl_tag    = RW'(ct);
    reset       = !rst;
    e.vld = '0; e.tags = '0; e.perr = 1'b0; e.cnt = 0;
    if (rst) begin
      mq.delete();
      foreach (m_done[i]) m_done[i] = 1'b0;
    end else begin
      k = 0;
      while (k < MC && k < mq.size() && m_done[mq[k]]) k++;
      in_ret = 1'b0;
      for (int i = 0; i < k; i++) begin
        e.vld[i]  = 1'b1;
        e.tags[i] = RW'(mq[i]);
        if (mq[i] == at) in_ret = 1'b1;
      end
      a_ok = av && (mq.size() < RS) && (!in_q(at) || in_ret);
      c_ok = cv && in_q(ct) && !m_done[ct];
      e.perr = (av && !a_ok) || (cv && !c_ok);
      if (c_ok) m_done[ct] = 1'b1;
      for (int i = 0; i < k; i++) begin
        m_done[mq[0]] = 1'b0;
        void'(mq.pop_front());
      end
      if (a_ok) begin
        mq.push_back(at);
        m_done[at] = 1'b0;
      end
      e.cnt = mq.size();
    end
    e.due = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic a(input int t);   step(1, t, 0, 0, 0); endtask
  task automatic c(input int t);   step(0, 0, 1, t, 0); endtask
  task automatic idle();           step(0, 0, 0, 0, 0); endtask
  task automatic rst();            step(0, 0, 0, 0, 1); endtask

  always @(negedge clk) begin
    exp_t                 e;
    logic [MC-1:0][RW-1:0] act;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL sb_missed actual=none expected=due%0d", e.due);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      for (int i = 0; i < MC; i++) act[i] = commited_tags[i];
      chk("sb_valid", 32'(commited_tags_valid), 32'(e.vld));
      chk("sb_tags", 32'(act), 32'(e.tags));
      chk("sb_perr", 32'(protocol_err), 32'(e.perr));
      chk("sb_count", 32'(inflight_count), 32'(e.cnt));
    end
  end

  initial begin
    bit av, cv, rs;
    int at, ct, aprob;
    @(posedge clk);
    #1;
    rst(); rst();
    chk("reset_valid", 32'(commited_tags_valid), 0);
    chk("reset_count", 32'(inflight_count), 0);
    chk("reset_perr", 32'(protocol_err), 0);

    // Out-of-order completion: tag 0 holds tag 1 until it is done.
    a(0); a(1); a(2);
    c(1);
    chk("ooo_no_commit1", 32'(commited_tags_valid), 0);
    c(0);
    chk("ooo_no_commit0", 32'(commited_tags_valid), 0);
    idle();
    chk("ooo_valid", 32'(commited_tags_valid), 3);
    chk("ooo_tag0", 32'(commited_tags[0]), 0);
    chk("ooo_tag1", 32'(commited_tags[1]), 1);
    chk("ooo_count", 32'(inflight_count), 1);
    c(2); idle(); idle();

    // Three ready entries drain two then one.
    rst();
    a(0); a(1); a(2);
    c(2); c(1); c(0);
    chk("lim_none", 32'(commited_tags_valid), 0);
    idle();
    chk("lim_valid1", 32'(commited_tags_valid), 3);
    chk("lim_tags1", {commited_tags[1], commited_tags[0]}, 32'h10);
    idle();
    chk("lim_valid2", 32'(commited_tags_valid), 1);
    chk("lim_tag2", 32'(commited_tags[0]), 2);
    chk("lim_count", 32'(inflight_count), 0);

    // Full queue rejects another alloc.
    rst();
    for (int t = 0; t < RS; t++) a(t);
    chk("full_count", 32'(inflight_count), RS);
    a(7);
    chk("full_perr", 32'(protocol_err), 1);
    chk("full_count2", 32'(inflight_count), RS);
    idle();
    chk("full_perr_pulse", 32'(protocol_err), 0);

    // Head and tail wrap: tags 14,15,0 sit at entries 14,15,0.
    rst();
    for (int t = 0; t < 14; t++) a(t);
    for (int t = 0; t < 14; t++) c(t);
    idle(); idle(); idle();
    chk("wrap_empty", 32'(inflight_count), 0);
    a(14); a(15); a(0);
    c(0); c(15); c(14);
    idle();
    chk("wrap_valid1", 32'(commited_tags_valid), 3);
    chk("wrap_tags1", {commited_tags[1], commited_tags[0]}, 32'hfe);
    idle();
    chk("wrap_valid2", 32'(commited_tags_valid), 1);
    chk("wrap_tag2", 32'(commited_tags[0]), 0);
    chk("wrap_count", 32'(inflight_count), 0);

    // Illegal completions are dropped.
    rst();
    a(2); a(3);
    c(3);
    c(5);
    chk("bad_cmpl_perr", 32'(protocol_err), 1);
    chk("bad_cmpl_valid", 32'(commited_tags_valid), 0);
    c(3);
    chk("dup_cmpl_perr", 32'(protocol_err), 1);
    chk("dup_cmpl_valid", 32'(commited_tags_valid), 0);
    idle();
    chk("dup_count", 32'(inflight_count), 2);
    chk("dup_perr_pulse", 32'(protocol_err), 0);

    // Reset wins over a pending commit and concurrent alloc/completion.
    rst();
    for (int t = 0; t < 6; t++) a(t);
    c(1); c(0);
    step(1, 6, 1, 2, 1);
    chk("midrst_valid", 32'(commited_tags_valid), 0);
    chk("midrst_tags", {commited_tags[1], commited_tags[0]}, 0);
    chk("midrst_count", 32'(inflight_count), 0);
    chk("midrst_perr", 32'(protocol_err), 0);
    idle();
    chk("midrst_no_commit", 32'(commited_tags_valid), 0);

    // Randomised traffic with varying alloc pressure and occasional illegal requests.
    aprob = 60;
    for (int n = 0; n < 4000; n++) begin
      if (n % 400 == 0) aprob = $urandom_range(20, 95);
      rs = ($urandom_range(0, 499) == 0);
      av = ($urandom_range(0, 99) < aprob);
      case ($urandom_range(0, 7))
        0:       at = $urandom_range(0, RS - 1);
        1:       at = (mq.size() > 0) ? mq[0] : pick_free();
        default: at = pick_free();
      endcase
      cv = ($urandom_range(0, 99) < 75);
      ct = ($urandom_range(0, 7) == 0) ? $urandom_range(0, RS - 1) : pick_pending();
      step(av, at, cv, ct, rs);
    end
    idle(); idle();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
